pwm_regs_slave: RTL and testbench



---
 rtl/pwm_regs_pkg.sv | 19 +
 rtl/pwm_regs_slave_if.sv | 16 +
 rtl/pwm_core.sv | 80 ++++++++
 rtl/pwm_regs_slave.sv | 114 +++++++++++
 tb/tb_pwm_regs_slave.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_regs_pkg.sv
// Shared constants for the PWM register slave: register addresses, FSM encoding, CTRL bit index.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pwm_regs_pkg;

   localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
   localparam logic [31:0] ADDR_PERIOD = 32'h0000_0004;
   localparam logic [31:0] ADDR_DUTY   = 32'h0000_0008;
   localparam logic [31:0] ADDR_STATUS = 32'h0000_000C;
   localparam logic [31:0] ADDR_IRQ    = 32'h0000_0010;

   localparam int CTRL_EN_BIT = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pwm_state_e;

endpackage

// File: rtl/pwm_regs_slave_if.sv
// cs/wr/rd register bus between the configuration sequencer (master) and the PWM slave.
// Latency: writes land on the strobe edge, read data is valid one cycle after the strobe.
// Backpressure: none; the slave accepts every access.
interface pwm_regs_slave_if #(
   parameter int ADDR_W = 32
) ();
   logic              cs;
   logic              wr;
   logic              rd;
   logic [ADDR_W-1:0] adr;
   logic [31:0]       d_in;
   logic [31:0]       d_out;

   modport master (output cs, output wr, output rd, output adr, output d_in, input d_out);
   modport slave  (input cs, input wr, input rd, input adr, input d_in, output d_out);
endinterface

// File: rtl/pwm_core.sv
// PWM engine: period counter, IDLE/RUN FSM, shadow load of period/duty, registered compare.
// Latency: pwm_out is registered and always equals (cnt < duty_a) for the cycle's cnt.
// Backpressure: none; staged values are taken only at safe points (disabled or wrap edge).
module pwm_core
   import pwm_regs_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [CNT_W-1:0] period_s_i,
   input  logic [CNT_W-1:0] duty_s_i,
   output logic             pwm_out_o,
   output logic             wrap_o,
   // Next-edge view of the counter so a read strobed on an edge reports the value after it.
   output logic             run_nxt_o,
   output logic [CNT_W-1:0] cnt_nxt_o
);

   pwm_state_e       st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_a_q, period_a_d;
   logic [CNT_W-1:0] duty_a_q, duty_a_d;
   logic             pwm_q, pwm_d;
   logic             at_end;
   logic             load;

   assign at_end = (cnt_q == period_a_q - CNT_W'(1));

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) st_q <= ST_IDLE;
      else       st_q <= st_d;
   end

   // Next state: start only with a non-zero active period; a zero period loaded at wrap stops the engine.
   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE: if (en_i && (period_a_q != '0)) st_d = ST_RUN;
         ST_RUN: begin
            if (!en_i)                            st_d = ST_IDLE;
            else if (at_end && period_s_i == '0) st_d = ST_IDLE;
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // Outputs and datapath next values: shadow load, count, compare against the next cycle's values.
   always_comb begin
      wrap_o     = (st_q == ST_RUN) && en_i && at_end;
      load       = !en_i || wrap_o;
      period_a_d = load ? period_s_i : period_a_q;
      duty_a_d   = load ? duty_s_i   : duty_a_q;
      cnt_d      = '0;
      if (st_q == ST_RUN && st_d == ST_RUN && !wrap_o) cnt_d = cnt_q + CNT_W'(1);
      pwm_d      = (st_d == ST_RUN) && (cnt_d < duty_a_d);
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         period_a_q <= '0;
         duty_a_q   <= '0;
         pwm_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         period_a_q <= period_a_d;
         duty_a_q   <= duty_a_d;
         pwm_q      <= pwm_d;
      end
   end

   assign pwm_out_o = pwm_q;
   assign run_nxt_o = (st_d == ST_RUN);
   assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/pwm_regs_slave.sv
// Memory-mapped PWM peripheral: bus decode, staged CTRL/PERIOD/DUTY, STATUS, optional IRQ (PWM_IRQ_EN).
// Latency: writes take effect on the strobe edge; d_out is registered, valid one cycle after a read.
// Backpressure: none; every access completes, a simultaneous write suppresses the read.
module pwm_regs_slave
   import pwm_regs_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   pwm_regs_slave_if.slave    bus,
   output logic               pwm_out,
   output logic               irq
);

   logic [ADDR_W-1:0] adr_w;
   logic [63:0]       adr_ext;
   logic              wr_en, rd_en;
   logic              hit_ctrl, hit_period, hit_duty, hit_status;

   logic              en_q;
   logic [CNT_W-1:0]  period_s_q, duty_s_q;
   logic [31:0]       d_out_q, rdata;

   logic              wrap;
   logic              run_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [30:0]       cnt_tr;

   // Full-address compare: upper bits must be zero and misaligned addresses never match.
   assign adr_w      = bus.adr;
   assign adr_ext    = 64'(adr_w);
   assign wr_en      = bus.cs && bus.wr;
   assign rd_en      = bus.cs && bus.rd && !bus.wr;
   assign hit_ctrl   = (adr_ext == 64'(ADDR_CTRL));
   assign hit_period = (adr_ext == 64'(ADDR_PERIOD));
   assign hit_duty   = (adr_ext == 64'(ADDR_DUTY));
   assign hit_status = (adr_ext == 64'(ADDR_STATUS));

   // Staged register file; STATUS is read-only so it has no write path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q       <= 1'b0;
         period_s_q <= '0;
         duty_s_q   <= '0;
      end else if (wr_en) begin
         if (hit_ctrl)   en_q       <= bus.d_in[CTRL_EN_BIT];
         if (hit_period) period_s_q <= bus.d_in[CNT_W-1:0];
         if (hit_duty)   duty_s_q   <= bus.d_in[CNT_W-1:0];
      end
   end

   pwm_core #(.CNT_W(CNT_W)) u_core (
      .clk        (clk),
      .reset      (reset),
      .en_i       (en_q),
      .period_s_i (period_s_q),
      .duty_s_i   (duty_s_q),
      .pwm_out_o  (pwm_out),
      .wrap_o     (wrap),
      .run_nxt_o  (run_nxt),
      .cnt_nxt_o  (cnt_nxt)
   );

   assign cnt_tr = 31'(cnt_nxt);

`ifdef PWM_IRQ_EN
   logic hit_irq;
   logic flag_q, flag_d;

   assign hit_irq = (adr_ext == 64'(ADDR_IRQ));

   // Sticky period-end flag; a wrap on the same edge as a software clear keeps it set.
   always_comb begin
      flag_d = flag_q;
      if (wr_en && hit_irq && bus.d_in[0]) flag_d = 1'b0;
      if (wrap)                             flag_d = 1'b1;
   end

   // Flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) flag_q <= 1'b0;
      else       flag_q <= flag_d;
   end

   assign irq = flag_q;
`else
   logic unused_wrap;
   assign unused_wrap = wrap;
   assign irq         = 1'b0;
`endif

   // Read mux: reports each register as it stands after the strobe edge; unmapped reads return 0.
   always_comb begin
      rdata = '0;
      if (hit_ctrl)   rdata[CTRL_EN_BIT] = en_q;
      if (hit_period) rdata = 32'(period_s_q);
      if (hit_duty)   rdata = 32'(duty_s_q);
      if (hit_status) rdata = {cnt_tr, run_nxt};
`ifdef PWM_IRQ_EN
      if (hit_irq)    rdata[0] = flag_d;
`endif
   end

   // Read data register holds until the next read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      d_out_q <= '0;
      else if (rd_en) d_out_q <= rdata;
   end

   assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_pwm_regs_slave.sv
// Self-checking bench for pwm_regs_slave: directed scenarios with literal expectations plus random traffic.
// A cycle-level reference model derived from the register-map rules is compared on every falling edge.
// Define PWM_IRQ_EN for both bench and RTL to exercise the interrupt register.
module tb_pwm_regs_slave;

   logic clk;
   logic reset;
   logic pwm_out;
   logic irq;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   pwm_regs_slave_if #(.ADDR_W(32)) bus ();

   pwm_regs_slave #(.CNT_W(32), .ADDR_W(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .pwm_out (pwm_out),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic        m_en, m_run, m_flag, m_pwm;
   logic [31:0] m_per, m_duty, m_pa, m_da, m_cnt, m_dout;

   function automatic logic [31:0] m_read(input logic [31:0] a);
      case (a)
         32'h0:   return {31'b0, m_en};
         32'h4:   return m_per;
         32'h8:   return m_duty;
         32'hC:   return {m_cnt[30:0], m_run};
`ifdef PWM_IRQ_EN
         32'h10:  return {31'b0, m_flag};
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_en = 0; m_run = 0; m_flag = 0; m_pwm = 0;
      m_per = 0; m_duty = 0; m_pa = 0; m_da = 0; m_cnt = 0; m_dout = 0;
   endtask

   task automatic m_step();
      logic        wr_e, rd_e, wrapped, run_n;
      logic [31:0] a, cnt_n;
      wr_e    = bus.cs && bus.wr;
      rd_e    = bus.cs && bus.rd && !bus.wr;
      a       = bus.adr;
      wrapped = m_run && m_en && (m_cnt == m_pa - 1);
      run_n   = m_run;
      cnt_n   = m_cnt;
      if (m_run) begin
         if (!m_en)        begin run_n = 0; cnt_n = 0; end
         else if (wrapped) begin cnt_n = 0; run_n = (m_per != 0); end
         else              cnt_n = m_cnt + 1;
      end else if (m_en && m_pa != 0) begin
         run_n = 1; cnt_n = 0;
      end
      if (!m_en || wrapped) begin m_pa = m_per; m_da = m_duty; end
      m_run = run_n;
      m_cnt = cnt_n;
`ifdef PWM_IRQ_EN
      if (wr_e && a == 32'h10 && bus.d_in[0]) m_flag = 0;
      if (wrapped) m_flag = 1;
`endif
      if (wr_e) begin
         case (a)
            32'h0: m_en   = bus.d_in[0];
            32'h4: m_per  = bus.d_in;
            32'h8: m_duty = bus.d_in;
            default: ;
         endcase
      end
      if (rd_e) m_dout = m_read(a);
      m_pwm = m_run && (m_cnt < m_da);
   endtask

   // Model advances on the same edges as the DUT, including the asynchronous reset.
   always @(posedge clk or posedge reset) begin
      if (reset) m_reset();
      else       m_step();
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every cycle against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_pwm_out", {31'b0, pwm_out}, {31'b0, m_pwm});
         chk("model_irq",     {31'b0, irq},     {31'b0, m_flag});
         chk("model_d_out",   bus.d_out,        m_dout);
      end
   end

   // ---------------- bus tasks ----------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.cs = 1; bus.wr = 1; bus.rd = 0; bus.adr = a; bus.d_in = d;
      @(posedge clk); #1;
      bus.cs = 0; bus.wr = 0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.cs = 1; bus.wr = 0; bus.rd = 1; bus.adr = a;
      @(posedge clk); #1;
      bus.cs = 0; bus.rd = 0;
      d = bus.d_out;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   logic [31:0] rd_v;
   logic [19:0] seq20;
   logic [14:0] seq15;
   int          ones;
   logic [31:0] addr_tab [8];

   initial begin
      addr_tab[0] = 32'h0;  addr_tab[1] = 32'h4;  addr_tab[2] = 32'h8;  addr_tab[3] = 32'hC;
      addr_tab[4] = 32'h10; addr_tab[5] = 32'h14; addr_tab[6] = 32'h6;  addr_tab[7] = 32'h44;

      reset = 1;
      bus.cs = 0; bus.wr = 0; bus.rd = 0; bus.adr = 0; bus.d_in = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      chk_en = 1;

      // Reset state.
      chk("reset_d_out",   bus.d_out, 32'h0);
      chk("reset_pwm_out", {31'b0, pwm_out}, 32'h0);
      chk("reset_irq",     {31'b0, irq}, 32'h0);
      bus_read(32'h4, rd_v);
      chk("reset_period_read", rd_v, 32'h0);

      // PERIOD=10 DUTY=3: three cycles high, seven low.
      bus_write(32'h4, 10);
      bus_write(32'h8, 3);
      bus_write(32'h0, 1);
      seq20 = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         seq20 = {seq20[18:0], pwm_out};
      end
      chk("pwm_3_of_10", {12'b0, seq20}, {12'b0, 20'b11100000001110000000});
`ifdef PWM_IRQ_EN
      chk("irq_after_first_wrap", {31'b0, irq}, 32'h1);
`endif
      bus_read(32'hC, rd_v);
      chk("status_running_cnt0", rd_v, 32'h1);
      bus_write(32'h10, 1);
`ifdef PWM_IRQ_EN
      chk("irq_cleared", {31'b0, irq}, 32'h0);
`endif

      // DUTY=7 written while cnt=4: current period keeps 3, next period is 7 high.
      idle(3);
      bus_write(32'h8, 7);
      seq15 = '0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         seq15 = {seq15[13:0], pwm_out};
      end
      chk("duty_change_next_period", {17'b0, seq15}, {17'b0, 15'b000011111110001});

      // PERIOD=0 with enable=1 never starts.
      bus_write(32'h0, 0);
      bus_write(32'h4, 0);
      bus_write(32'h0, 1);
      idle(2);
      bus_read(32'hC, rd_v);
      chk("period0_not_running", rd_v, 32'h0);

      // DUTY >= PERIOD gives constant high.
      bus_write(32'h0, 0);
      bus_write(32'h4, 10);
      bus_write(32'h8, 12);
      bus_write(32'h0, 1);
      ones = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         ones += int'(pwm_out);
      end
      chk("duty12_const_high", ones, 12);

      // Asynchronous reset mid-period clears the output at once and loses config.
      #2 reset = 1;
      #1 chk("async_reset_pwm", {31'b0, pwm_out}, 32'h0);
      @(posedge clk); #1 reset = 0;
      bus_read(32'h4, rd_v);
      chk("period_lost_after_reset", rd_v, 32'h0);

      // DUTY=0 gives constant low while still running.
      bus_write(32'h4, 10);
      bus_write(32'h8, 0);
      bus_write(32'h0, 1);
      ones = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         ones += int'(pwm_out);
      end
      chk("duty0_const_low", ones, 0);
      bus_read(32'hC, rd_v);
      chk("status_cnt2_running", rd_v, 32'h5);

      // Simultaneous write and read: write lands, d_out holds.
      bus_read(32'h0, rd_v);
      chk("ctrl_read", rd_v, 32'h1);
      bus.cs = 1; bus.wr = 1; bus.rd = 1; bus.adr = 32'h8; bus.d_in = 5;
      @(posedge clk); #1;
      bus.cs = 0; bus.wr = 0; bus.rd = 0;
      chk("wr_rd_dout_holds", bus.d_out, 32'h1);
      bus_read(32'h8, rd_v);
      chk("wr_rd_duty_written", rd_v, 32'h5);
      bus_read(32'h14, rd_v);
      chk("unmapped_read_zero", rd_v, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         int r;
         int sel;
         r      = $urandom_range(0, 9);
         sel    = $urandom_range(0, 7);
         bus.cs = ($urandom_range(0, 7) != 0);
         bus.wr = (r < 2) || (r == 6);
         bus.rd = (r >= 2 && r < 5) || (r == 6);
         bus.adr = addr_tab[sel];
         case (sel)
            0:       bus.d_in = ($urandom & 32'hFFFF_FFFE) | 32'(($urandom_range(0, 4) != 0));
            1:       bus.d_in = $urandom_range(0, 12);
            2:       bus.d_in = $urandom_range(0, 14);
            default: bus.d_in = $urandom;
         endcase
         @(posedge clk); #1;
      end
      bus.cs = 0; bus.wr = 0; bus.rd = 0;
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
